// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and FSM state type for the line transfer engine
package cache_pkg;

    localparam int LINE_BYTES = 4;
    localparam int ADDR_W     = 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_LAST = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_line_xfer_if.sv
// rtl/mem_line_xfer_if.sv - cache request/response and byte-memory signals of the line transfer engine
interface mem_line_xfer_if #(
    parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
    parameter int ADDR_W     = cache_pkg::ADDR_W
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [LINE_BYTES*8-1:0] req_wline;
    logic                    resp_valid;
    logic [LINE_BYTES*8-1:0] resp_rline;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_wdata;
    logic [7:0]              mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wline, mem_rdata,
        input  req_ready, resp_valid, resp_rline, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wline, mem_rdata,
        output req_ready, resp_valid, resp_rline, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_line_xfer.sv
// rtl/mem_line_xfer.sv - moves one cache line to or from a byte-wide main memory, one byte per cycle
module mem_line_xfer #(
    parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
    parameter int ADDR_W     = cache_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_line_xfer_if.slave  bus
);
    import cache_pkg::*;

    localparam int LW     = LINE_BYTES * 8;
    localparam int BEAT_W = $clog2(LINE_BYTES) + 1;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic [LW-9:0]       wbuf;
    logic [LW-9:0]       rbuf;
    logic [LW-1:0]       rline_q;
    logic [LW-1:0]       rcat;
    logic                last_beat;
    logic                accept;
    logic                ready_c, resp_c, we_c;

    assign last_beat = (beat + BEAT_W'(1)) == BEAT_W'(LINE_BYTES);
    assign accept    = bus.req_valid & ready_c;
    // Newest byte enters at the top so byte 0 ends up in the low lane after the last capture.
    assign rcat      = {bus.mem_rdata, rbuf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        resp_c    = 1'b0;
        we_c      = 1'b0;
        case (state)
            IDLE: begin
                ready_c = rst_n;
                if (bus.req_valid && rst_n) state_nxt = bus.req_write ? WR : RD;
            end
            RD:      if (last_beat) state_nxt = RD_LAST;
            RD_LAST: state_nxt = RESP;
            WR: begin
                we_c = 1'b1;
                if (last_beat) state_nxt = RESP;
            end
            RESP: begin
                resp_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbuf    <= '0;
            rbuf    <= '0;
            rline_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    beat   <= '0;
                    addr_q <= bus.req_addr & ~ADDR_W'(LINE_BYTES - 1);
                    if (bus.req_write) begin
                        wdata_q <= bus.req_wline[7:0];
                        wbuf    <= bus.req_wline[LW-1:8];
                    end
                end
                RD: begin
                    // Memory data lags the address by a cycle, so beat 0 has nothing to capture yet.
                    if (beat != '0) rbuf <= rcat[LW-1:8];
                    if (!last_beat) begin
                        beat   <= beat + BEAT_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                RD_LAST: rline_q <= rcat;
                WR: if (!last_beat) begin
                    beat    <= beat + BEAT_W'(1);
                    addr_q  <= addr_q + ADDR_W'(1);
                    wdata_q <= wbuf[7:0];
                    wbuf    <= wbuf >> 8;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_c;
    assign bus.resp_rline = rline_q;
    assign bus.mem_we     = we_c;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_line_xfer.sv
// tb/tb_mem_line_xfer.sv - directed vector bench for mem_line_xfer against a 256-byte memory model
module tb_mem_line_xfer;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_load;
    logic [7:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_line_xfer_if bus ();

    mem_line_xfer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wline;
        logic [31:0] exp_line;
        int          exp_lat;
        logic [7:0]  exp_base;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int   waited;
        int   resp_c;
        int   resp_n;
        logic beats_ok;
        logic busy_ok;
        logic [31:0] rline_at_resp;
        logic [7:0]  addr_after;
        logic [7:0]  exp_byte;
        waited = 0;
        resp_c = -1;
        resp_n = 0;
        beats_ok = 1'b1;
        busy_ok = 1'b1;
        rline_at_resp = 'x;
        addr_after = 'x;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wline = v.wline;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d_accept", idx), 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                resp_n++;
                if (resp_c < 0) begin
                    resp_c = c;
                    rline_at_resp = bus.resp_rline;
                end
            end
            if (c <= v.exp_lat && bus.req_ready !== 1'b0) busy_ok = 1'b0;
            if (c <= 4) begin
                exp_byte = v.wline[8*(c-1) +: 8];
                if (bus.mem_addr !== v.exp_base + 8'(c - 1)) beats_ok = 1'b0;
                if (bus.mem_we !== v.wr) beats_ok = 1'b0;
                if (v.wr && bus.mem_wdata !== exp_byte) beats_ok = 1'b0;
            end else if (bus.mem_we !== 1'b0) begin
                beats_ok = 1'b0;
            end
            if (c == v.exp_lat + 2) addr_after = bus.mem_addr;
        end
        check($sformatf("v%0d_latency", idx), 32'(resp_c), 32'(v.exp_lat));
        check($sformatf("v%0d_resp_pulses", idx), 32'(resp_n), 32'd1);
        check($sformatf("v%0d_rline", idx), rline_at_resp, v.exp_line);
        check($sformatf("v%0d_beats", idx), 32'(beats_ok), 32'd1);
        check($sformatf("v%0d_busy_not_ready", idx), 32'(busy_ok), 32'd1);
        check($sformatf("v%0d_idle_addr_hold", idx), 32'(addr_after), 32'(v.exp_base + 8'd3));
        if (v.wr)
            check($sformatf("v%0d_mem_bytes", idx),
                  {mem[v.exp_base+8'd3], mem[v.exp_base+8'd2], mem[v.exp_base+8'd1], mem[v.exp_base]},
                  v.wline);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ready_ok;
        logic resp_seen;
        int   acc2;
        int   resp_cyc [$];
        logic [31:0] line2;

        vecs[0] = '{1'b0, 8'h24, 32'h0,        32'h27262524, 6, 8'h24};
        vecs[1] = '{1'b1, 8'h40, 32'hDEADBEEF, 32'h27262524, 5, 8'h40};
        vecs[2] = '{1'b0, 8'h40, 32'h0,        32'hDEADBEEF, 6, 8'h40};
        vecs[3] = '{1'b0, 8'h27, 32'h0,        32'h27262524, 6, 8'h24};
        vecs[4] = '{1'b0, 8'hFC, 32'h0,        32'hFFFEFDFC, 6, 8'hFC};
        vecs[5] = '{1'b1, 8'h13, 32'hA5A50102, 32'hFFFEFDFC, 5, 8'h10};
        vecs[6] = '{1'b0, 8'h10, 32'h0,        32'hA5A50102, 6, 8'h10};

        rst_n = 1'b0;
        mem_load = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wline = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_resp_rline", bus.resp_rline, 32'd0);
        @(negedge clk);
        mem_load = 1'b0;
        rst_n = 1'b1;
        #1 check("ready_after_reset", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back reads with req_valid held: second accept in the IDLE after RESP.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h24;
        ready_ok = 1'b1;
        acc2 = -1;
        line2 = 'x;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) bus.req_addr = 8'h08;
            if (c == 8) bus.req_valid = 1'b0;
            if (bus.resp_valid) resp_cyc.push_back(c);
            if (c >= 1 && c <= 6 && bus.req_ready !== 1'b0) ready_ok = 1'b0;
            if (c >= 1 && acc2 < 0 && bus.req_ready === 1'b1 && bus.req_valid) acc2 = c;
            if (c == 14) line2 = bus.resp_rline;
        end
        check("b2b_busy_not_ready", 32'(ready_ok), 32'd1);
        check("b2b_second_accept", 32'(acc2), 32'd7);
        check("b2b_resp_count", 32'(resp_cyc.size()), 32'd2);
        if (resp_cyc.size() == 2) begin
            check("b2b_resp1_cycle", 32'(resp_cyc[0]), 32'd6);
            check("b2b_resp2_cycle", 32'(resp_cyc[1]), 32'd13);
        end
        check("b2b_line2", line2, 32'h0B0A0908);

        // Reset mid-write after two beats.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h80;
        bus.req_wline = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_we_before_rst", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we_async_clear", 32'(bus.mem_we), 32'd0);
        check("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
        resp_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) resp_seen = 1'b1;
        end
        rst_n = 1'b1;
        #1 check("abort_ready_after_release", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) resp_seen = 1'b1;
        end
        check("abort_no_resp", 32'(resp_seen), 32'd0);
        check("abort_mem_bytes", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'h83823344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_line_xfer.md
MEM_LINE_XFER -- requirements
Module: mem_line_xfer

Interface
REQ-001 Parameter LINE_BYTES, default 4, bytes per cache line; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_W, default 8, byte-address width; SHALL match the 256-byte main memory.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  cache requests a line transfer.
REQ-006 req_ready  output  1  block accepts a request; transfer on posedge with req_valid & req_ready.
REQ-007 req_write  input  1  1 = write line to memory, 0 = fill line from memory.
REQ-008 req_addr  input  ADDR_W  line address; low log2(LINE_BYTES) bits SHALL be ignored.
REQ-009 req_wline  input  LINE_BYTES*8  write-back line; byte i = bits [8i+7:8i].
REQ-010 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rline  output  LINE_BYTES*8  filled line, little-endian as REQ-009.
REQ-012 mem_we  output  1  byte write enable to main memory.
REQ-013 mem_addr  output  ADDR_W  byte address to main memory.
REQ-014 mem_wdata  output  8  byte write data to main memory.
REQ-015 mem_rdata  input  8  main-memory read data, valid one cycle after mem_addr is sampled.

Function
REQ-016 FSM states SHALL be IDLE, RD, RD_LAST, WR, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; request fields SHALL be latched on acceptance.
REQ-018 Base address SHALL be req_addr with its low log2(LINE_BYTES) bits forced to 0.
REQ-019 Beat addresses SHALL be base+0 .. base+LINE_BYTES-1 and never wrap, because the base is aligned.
REQ-020 Read timing (accept at cycle T, LINE_BYTES=4):
- RD during T+1..T+4, with mem_addr = base+i in cycle T+1+i.
- Byte i of mem_rdata is captured at the end of cycle T+2+i.
- RD_LAST in T+5 captures the final byte.
- RESP in T+6.
REQ-021 Write timing: WR during T+1..T+4, with mem_we=1, mem_addr=base+i and mem_wdata=byte i in cycle T+1+i; RESP in T+5.
REQ-022 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 resp_rline SHALL update only at the end of a read and hold its value otherwise, including across writes.
REQ-024 Outside WR, mem_we SHALL be 0; in IDLE, mem_addr and mem_wdata SHALL hold their last values.
REQ-025 Memory-side outputs SHALL depend only on registered state, with no combinational path from req_* inputs.
REQ-026 A request held through RESP SHALL be accepted in the following IDLE cycle, not earlier.
REQ-027 Beat counter SHALL be log2(LINE_BYTES)+1 bits wide, so terminal counts need no overflow.

Reset
REQ-028 While rst_n=0:
- state = IDLE, beat counter = 0;
- req_ready, resp_valid, mem_we = 0;
- mem_addr, mem_wdata, resp_rline = 0.
REQ-029 Reset asserted mid-transfer SHALL deassert mem_we immediately (asynchronously) and abandon the transfer without resp_valid; bytes already written SHALL remain written.
REQ-030 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 Shared package cache_pkg SHALL hold the FSM state enum, LINE_BYTES, ADDR_W and the offset-width constant.
REQ-032 No sub-module is required; the shift/assembly register SHALL be inline.

Verification (memory initialised so that mem[i]=i)
REQ-033 Read req_addr=0x24 at T -> resp_valid only at T+6, resp_rline=0x27262524, mem_we=0 throughout.
REQ-034 Write req_addr=0x40, req_wline=0xDEADBEEF -> mem[0x40..0x43]=EF,BE,AD,DE; resp_valid at T+5; a following read of 0x40 returns 0xDEADBEEF.
REQ-035 Unaligned read 0x27 -> behaves as base 0x24; top line 0xFC -> 0xFFFEFDFC, with addresses 0xFC..0xFF and no wrap to 0x00.
REQ-036 req_valid held high for two reads -> second accepted in the IDLE cycle after the first RESP; req_ready=0 during all busy cycles.
REQ-037 Write 0x80 line 0x11223344 with rst_n pulsed low after 2 beats -> mem_we falls without waiting for a clock, mem[0x80]=44, mem[0x81]=33, mem[0x82..0x83] unchanged, no resp_valid, req_ready=1 after release.
